// File: rtl/z80_seq_pkg.sv
// rtl/z80_seq_pkg.sv - shared types and helpers for the indexed load/store sequencer
package z80_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DISP = 3'd1,
        S_ADDR = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_RET  = 3'd5
    } seq_state_t;

    localparam logic [3:0] REG_IX = 4'd8;
    localparam logic [3:0] REG_IY = 4'd9;

    function automatic logic [15:0] disp_ext(input logic [7:0] d, input logic signed_mode);
        return signed_mode ? {{8{d[7]}}, d} : {8'h00, d};
    endfunction

endpackage

// File: rtl/z80_ixiy_mem_sequencer.sv
// rtl/z80_ixiy_mem_sequencer.sv - LD (IX/IY+d),r and LD r,(IX/IY+d) multi-cycle sequencer
module z80_ixiy_mem_sequencer
    import z80_seq_pkg::*;
#(
    parameter bit DISP_SIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        idle,
    input  logic        insn_iy,
    input  logic        insn_store,
    input  logic [2:0]  insn_r,
    input  logic [15:0] pc_in,
    output logic [3:0]  reg1_rnum,
    input  logic [15:0] reg1_rdata,
    output logic [3:0]  reg2_rnum,
    input  logic [15:0] reg2_rdata,
    output logic        reg_wr,
    output logic [3:0]  reg_wnum,
    output logic [7:0]  reg_wdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        retire,
    output logic [15:0] retire_pc,
    output logic [15:0] retire_addr,
    output logic        illegal
);

    seq_state_t  state, state_nx;
    logic        iy_q, store_q, illegal_q;
    logic [2:0]  r_q;
    logic [15:0] pc_q, ea_q;
    logic [7:0]  d_q, byte_q;
    logic        accept;
    logic        unused_hi;

    // Only the low byte of the data register is ever stored.
    assign unused_hi = ^reg2_rdata[15:8];
    assign accept    = (state == S_IDLE) && start && (insn_r != 3'b110);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            iy_q      <= 1'b0;
            store_q   <= 1'b0;
            r_q       <= 3'd0;
            pc_q      <= 16'h0000;
            d_q       <= 8'h00;
            ea_q      <= 16'h0000;
            byte_q    <= 8'h00;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nx;
            illegal_q <= (state == S_IDLE) && start && (insn_r == 3'b110);
            if (accept) begin
                iy_q    <= insn_iy;
                store_q <= insn_store;
                r_q     <= insn_r;
                pc_q    <= pc_in;
            end
            if (state == S_DISP && mem_ready) begin
                d_q <= mem_rdata;
            end
            if (state == S_ADDR) begin
                ea_q <= reg1_rdata + disp_ext(d_q, DISP_SIGNED);
                if (store_q) begin
                    byte_q <= reg2_rdata[7:0];
                end
            end
            if (state == S_MEM && mem_ready && !store_q) begin
                byte_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        idle        = 1'b0;
        reg1_rnum   = 4'd0;
        reg2_rnum   = 4'd0;
        reg_wr      = 1'b0;
        reg_wnum    = 4'd0;
        reg_wdata   = 8'h00;
        mem_valid   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 16'h0000;
        mem_wdata   = 8'h00;
        retire      = 1'b0;
        retire_pc   = 16'h0000;
        retire_addr = 16'h0000;
        illegal     = illegal_q;
        case (state)
            S_IDLE: begin
                idle = 1'b1;
                if (accept) state_nx = S_DISP;
            end
            S_DISP: begin
                mem_valid = 1'b1;
                mem_addr  = pc_q + 16'd2;
                if (mem_ready) state_nx = S_ADDR;
            end
            S_ADDR: begin
                reg1_rnum = iy_q ? REG_IY : REG_IX;
                reg2_rnum = store_q ? {1'b0, r_q} : 4'd0;
                state_nx  = S_MEM;
            end
            S_MEM: begin
                mem_valid = 1'b1;
                mem_we    = store_q;
                mem_addr  = ea_q;
                mem_wdata = store_q ? byte_q : 8'h00;
                if (mem_ready) state_nx = store_q ? S_RET : S_WB;
            end
            S_WB: begin
                reg_wr    = 1'b1;
                reg_wnum  = {1'b0, r_q};
                reg_wdata = byte_q;
                state_nx  = S_RET;
            end
            S_RET: begin
                retire      = 1'b1;
                retire_pc   = pc_q + 16'd3;
                retire_addr = ea_q;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_z80_ixiy_mem_sequencer.sv
// tb/tb_z80_ixiy_mem_sequencer.sv - directed vector bench for the indexed load/store sequencer
module tb_z80_ixiy_mem_sequencer;
    import z80_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        insn_iy = 1'b0;
    logic        insn_store = 1'b0;
    logic [2:0]  insn_r = 3'd0;
    logic [15:0] pc_in = 16'h0000;
    logic [15:0] reg1_rdata, reg2_rdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;

    logic        idle, reg_wr, mem_valid, mem_we, retire, illegal;
    logic [3:0]  reg1_rnum, reg2_rnum, reg_wnum;
    logic [7:0]  reg_wdata, mem_wdata;
    logic [15:0] mem_addr, retire_pc, retire_addr;

    logic        s_idle, s_reg_wr, s_mem_valid, s_mem_we, s_retire, s_illegal;
    logic [3:0]  s_reg1_rnum, s_reg2_rnum, s_reg_wnum;
    logic [7:0]  s_reg_wdata, s_mem_wdata;
    logic [15:0] s_mem_addr, s_retire_pc, s_retire_addr;

    logic [7:0]  mem [0:65535];
    logic [15:0] rf [0:15];
    logic [15:0] disp_addr = 16'h0000;
    int          cur_waits = 0;
    int          wcnt = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign reg1_rdata = rf[reg1_rnum];
    assign reg2_rdata = rf[reg2_rnum];
    assign mem_rdata  = mem[mem_addr];
    assign mem_ready  = mem_valid && ((mem_addr == disp_addr) || (wcnt == cur_waits));

    always @(posedge clk) begin
        if (!mem_valid || mem_ready) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    z80_ixiy_mem_sequencer #(.DISP_SIGNED(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .idle(idle),
        .insn_iy(insn_iy), .insn_store(insn_store), .insn_r(insn_r), .pc_in(pc_in),
        .reg1_rnum(reg1_rnum), .reg1_rdata(reg1_rdata),
        .reg2_rnum(reg2_rnum), .reg2_rdata(reg2_rdata),
        .reg_wr(reg_wr), .reg_wnum(reg_wnum), .reg_wdata(reg_wdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .retire(retire), .retire_pc(retire_pc), .retire_addr(retire_addr), .illegal(illegal)
    );

    z80_ixiy_mem_sequencer #(.DISP_SIGNED(1'b1)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(start), .idle(s_idle),
        .insn_iy(insn_iy), .insn_store(insn_store), .insn_r(insn_r), .pc_in(pc_in),
        .reg1_rnum(s_reg1_rnum), .reg1_rdata(reg1_rdata),
        .reg2_rnum(s_reg2_rnum), .reg2_rdata(reg2_rdata),
        .reg_wr(s_reg_wr), .reg_wnum(s_reg_wnum), .reg_wdata(s_reg_wdata),
        .mem_valid(s_mem_valid), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .retire(s_retire), .retire_pc(s_retire_pc), .retire_addr(s_retire_addr), .illegal(s_illegal)
    );

    logic [81:0] obs;
    assign obs = {idle, reg1_rnum, reg2_rnum, reg_wr, reg_wnum, reg_wdata, mem_valid, mem_we,
                  mem_addr, mem_wdata, retire, retire_pc, retire_addr, illegal};
    localparam logic [81:0] RST_OBS = {1'b1, 81'd0};

    typedef struct {
        logic        iy;
        logic        store;
        logic [2:0]  r;
        logic [15:0] pc;
        logic [15:0] idx;
        logic [7:0]  d;
        logic [7:0]  data;
        int          waits;
        logic        poke;
        logic [15:0] ea;
        logic [15:0] ea_s;
        logic [15:0] rpc;
        int          lat;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name, input logic [81:0] act, input logic [81:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic [15:0] da;
        logic [25:0] prev_bus = '0;
        logic        prev_wait = 1'b0;
        int ret_cyc = -1, wcyc = -1, wbcyc = -1, wn = 0, wbn = 0, ill = 0;
        logic [15:0] rpc = '0, raddr = '0, sraddr = '0, waddr = '0;
        logic [7:0]  wdata = '0, wbdata = '0;
        logic [3:0]  wbnum = '0;
        string       tag;
        tag = $sformatf("v%0d", k);
        da = v.pc + 16'd2;
        rf[REG_IX] = 16'hDEAD;
        rf[REG_IY] = 16'hBEEF;
        rf[v.iy ? REG_IY : REG_IX] = v.idx;
        rf[{1'b0, v.r}] = {8'hAA, v.data};
        mem[da] = v.d;
        if (!v.store) mem[v.ea] = v.data;
        disp_addr = da;
        cur_waits = v.waits;
        @(negedge clk);
        start = 1'b1; insn_iy = v.iy; insn_store = v.store; insn_r = v.r; pc_in = v.pc;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (mem_valid && prev_wait)
                chk({tag, " bus_stable"}, {56'd0, mem_addr, mem_we, mem_wdata, mem_valid}, {56'd0, prev_bus});
            prev_wait = mem_valid && !mem_ready;
            prev_bus  = {mem_addr, mem_we, mem_wdata, mem_valid};
            if (mem_valid && mem_ready && mem_we) begin
                wn++; wcyc = cyc; waddr = mem_addr; wdata = mem_wdata;
            end
            if (reg_wr) begin
                wbn++; wbcyc = cyc; wbnum = reg_wnum; wbdata = reg_wdata;
            end
            if (illegal) ill++;
            if (retire) begin
                ret_cyc = cyc; rpc = retire_pc; raddr = retire_addr; sraddr = s_retire_addr;
                break;
            end
            start = v.poke && mem_valid && (cyc >= 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " latency"}, 82'(ret_cyc), 82'(v.lat));
        chk({tag, " retire_pc"}, {66'd0, rpc}, {66'd0, v.rpc});
        chk({tag, " retire_addr"}, {66'd0, raddr}, {66'd0, v.ea});
        chk({tag, " retire_addr_signed"}, {66'd0, sraddr}, {66'd0, v.ea_s});
        chk({tag, " illegal"}, 82'(ill), 82'd0);
        if (v.store) begin
            chk({tag, " write_count"}, 82'(wn), 82'd1);
            chk({tag, " write_cycle"}, 82'(wcyc), 82'(3 + v.waits));
            chk({tag, " write_addr_data"}, {58'd0, waddr, wdata}, {58'd0, v.ea, v.data});
            chk({tag, " no_reg_wr"}, 82'(wbn), 82'd0);
        end else begin
            chk({tag, " reg_wr_count"}, 82'(wbn), 82'd1);
            chk({tag, " reg_wr_cycle"}, 82'(wbcyc), 82'(4 + v.waits));
            chk({tag, " reg_wnum_wdata"}, {70'd0, wbnum, wbdata}, {70'd0, 1'b0, v.r, v.data});
            chk({tag, " no_mem_write"}, 82'(wn), 82'd0);
        end
        @(negedge clk);
        chk({tag, " back_idle"}, {80'd0, idle, retire}, {80'd0, 1'b1, 1'b0});
        cur_waits = 0;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

        //        iy    st    r     pc        idx       d      data   w  poke  ea        ea_s      rpc       lat
        vt[0] = '{1'b0, 1'b1, 3'd0, 16'h0100, 16'h1000, 8'h05, 8'h5A, 0, 1'b0, 16'h1005, 16'h1005, 16'h0103, 4};
        vt[1] = '{1'b1, 1'b0, 3'd3, 16'h0200, 16'h20FE, 8'h03, 8'hC3, 0, 1'b0, 16'h2101, 16'h2101, 16'h0203, 5};
        vt[2] = '{1'b0, 1'b1, 3'd7, 16'hFFFE, 16'hFFFF, 8'h01, 8'h77, 0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 4};
        vt[3] = '{1'b0, 1'b1, 3'd1, 16'h0500, 16'h1000, 8'hFE, 8'h11, 0, 1'b0, 16'h10FE, 16'h0FFE, 16'h0503, 4};
        vt[4] = '{1'b0, 1'b1, 3'd2, 16'h1234, 16'h3000, 8'h10, 8'h99, 3, 1'b1, 16'h3010, 16'h3010, 16'h1237, 7};
        vt[5] = '{1'b1, 1'b0, 3'd5, 16'h0300, 16'h4000, 8'h80, 8'h3C, 1, 1'b0, 16'h4080, 16'h3F80, 16'h0303, 6};

        repeat (3) @(negedge clk);
        chk("reset_outputs", obs, RST_OBS);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", obs, RST_OBS);

        for (int k = 0; k < 6; k++) run_vec(k, vt[k]);

        // r == (HL) encoding: rejected with a one-cycle illegal pulse and no bus traffic
        @(negedge clk);
        start = 1'b1; insn_store = 1'b0; insn_r = 3'b110; pc_in = 16'h0600;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_pulse", {79'd0, illegal, idle, mem_valid}, {79'd0, 3'b110});
        @(negedge clk);
        chk("illegal_one_cycle", {79'd0, illegal, idle, mem_valid}, {79'd0, 3'b010});

        // reset asserted while the data cycle is stalled
        rf[REG_IX] = 16'h1000;
        mem[16'h0402] = 8'h05;
        disp_addr = 16'h0402;
        cur_waits = 10;
        @(negedge clk);
        start = 1'b1; insn_iy = 1'b0; insn_store = 1'b0; insn_r = 3'd1; pc_in = 16'h0400;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (mem_valid && mem_addr == 16'h1005) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_mem_phase", 82'(found), 82'd1);
        #2 reset_n = 1'b0;
        #1 chk("reset_mid_mem", obs, RST_OBS);
        chk("reset_mid_mem_signed", {81'd0, s_mem_valid}, 82'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cur_waits = 0;
        @(negedge clk);
        @(negedge clk);
        chk("after_reset_release", obs, RST_OBS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
